// File: rtl/ads_pkg.sv
// Shared types and default constants for the ADS serial ADC sample reader.
package ads_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONV    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_READ    = 3'd4,
    ST_DONE    = 3'd5
  } ads_rd_state_t;

  localparam int unsigned ADS_DATA_W     = 16;
  localparam int unsigned ADS_SCLK_DIV   = 2;
  localparam int unsigned ADS_CONV_PULSE = 4;
  localparam int unsigned ADS_BUSY_TO    = 200;

  function automatic int unsigned ads_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned ADS_CNT_W = $clog2(ads_max(ADS_CONV_PULSE, ADS_BUSY_TO) + 1);
  localparam int unsigned ADS_BIT_W = $clog2(ADS_DATA_W + 1);
  localparam int unsigned ADS_DIV_W = $clog2(ADS_SCLK_DIV);

endpackage

// File: rtl/ads_sync2.sv
// Two-flop synchronizer for asynchronous ADC status pins; resets to 0.
module ads_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Double-register the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ads_sample_reader.sv
// One ADC conversion per sample_en: CONVST pulse, BUSY handshake, serial read.
module ads_sample_reader
  import ads_pkg::*;
#(
  parameter int unsigned DATA_W     = ADS_DATA_W,
  parameter int unsigned SCLK_DIV   = ADS_SCLK_DIV,
  parameter int unsigned CONV_PULSE = ADS_CONV_PULSE,
  parameter int unsigned BUSY_TO    = ADS_BUSY_TO
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              sample_en,
  input  logic              ads_busy,
  input  logic              ads_sdo,
  output logic              ads_convst_n,
  output logic              ads_cs_n,
  output logic              ads_sclk,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              overrun,
  output logic              conv_err
);

  localparam int unsigned CNT_W = $clog2(ads_max(CONV_PULSE, BUSY_TO) + 1);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam int unsigned DIV_W = $clog2(SCLK_DIV);

  logic busy_s;

  ads_rd_state_t     state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [BIT_W-1:0]  bit_q,      bit_d;
  logic [DIV_W-1:0]  div_q,      div_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic [DATA_W-1:0] data_q,     data_d;
  logic              convst_n_q, convst_n_d;
  logic              cs_n_q,     cs_n_d;
  logic              sclk_q,     sclk_d;
  logic              valid_q,    valid_d;
  logic              overrun_q,  overrun_d;
  logic              err_q,      err_d;

  ads_sync2 u_busy_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (ads_busy),
    .q     (busy_s)
  );

  // Next-state logic for FSM, counters, serial clock and capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    div_d      = div_q;
    shift_d    = shift_q;
    data_d     = data_q;
    convst_n_d = convst_n_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    overrun_d  = sample_en && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sample_en) begin
          state_d    = ST_CONV;
          convst_n_d = 1'b0;
        end
      end
      ST_CONV: begin
        if (cnt_q == CNT_W'(CONV_PULSE - 1)) begin
          state_d    = ST_WAIT_HI;
          convst_n_d = 1'b1;
          cnt_d      = '0;
        end
      end
      ST_WAIT_HI: begin
        if (busy_s) begin
          state_d = ST_WAIT_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (!busy_s) begin
          state_d = ST_READ;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        cnt_d = '0;
        if (div_q == DIV_W'(SCLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            shift_d = {shift_q[DATA_W-2:0], ads_sdo};
            bit_d   = bit_q + 1'b1;
          end else if (bit_q == BIT_W'(DATA_W)) begin
            // Leave on the falling edge so the last sclk period is full length
            state_d = ST_DONE;
            cs_n_d  = 1'b1;
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      convst_n_q <= 1'b1;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      convst_n_q <= convst_n_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      err_q      <= err_d;
    end
  end

  assign ads_convst_n = convst_n_q;
  assign ads_cs_n     = cs_n_q;
  assign ads_sclk     = sclk_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign conv_err     = err_q;

endmodule

// File: tb/tb_ads_sample_reader.sv
// Scoreboard bench for ads_sample_reader with a behavioural ADC model.
module tb_ads_sample_reader;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        sample_en = 1'b0;
  logic        ads_busy = 1'b0;
  logic        ads_sdo = 1'b0;
  logic        ads_convst_n;
  logic        ads_cs_n;
  logic        ads_sclk;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        overrun;
  logic        conv_err;

  ads_sample_reader #(
    .DATA_W     (16),
    .SCLK_DIV   (2),
    .CONV_PULSE (4),
    .BUSY_TO    (200)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .sample_en    (sample_en),
    .ads_busy     (ads_busy),
    .ads_sdo      (ads_sdo),
    .ads_convst_n (ads_convst_n),
    .ads_cs_n     (ads_cs_n),
    .ads_sclk     (ads_sclk),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .conv_err     (conv_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  int          exp_err_q[$];

  int vld_seen = 0;
  int ovr_seen = 0;
  int err_seen = 0;
  int cs_low_total = 0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // ADC serial model: MSB driven at CS fall, next bit after each SCLK fall
  logic [15:0] adc_word = 16'h0000;
  int          adc_idx = 0;

  always @(negedge ads_cs_n) begin
    adc_idx = 15;
    ads_sdo = adc_word[adc_idx];
  end

  always @(negedge ads_sclk) begin
    if (ads_cs_n == 1'b0 && adc_idx > 0) begin
      adc_idx--;
      ads_sdo = adc_word[adc_idx];
    end
  end

  // Monitor: samples on the falling clock edge and checks against the queues
  int   conv_low = 0, t_conv = -1000;
  int   read_len = 0, rises = 0, hi_len = 0, lo_len = 0, bad = 0;
  int   busy_fall_t = -1;
  logic prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_busy = 1'b0;
  logic [15:0] exp_w;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      conv_low = 0; t_conv = -1000;
      read_len = 0; rises = 0; hi_len = 0; lo_len = 0; bad = 0;
      busy_fall_t = -1;
    end else begin
      if (!ads_convst_n) begin
        conv_low++;
        t_conv = -1;
      end else begin
        if (conv_low != 0) begin
          chk("convst_low_width", conv_low, 4);
          conv_low = 0;
        end
        t_conv++;
      end

      if (sample_valid) begin
        vld_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid actual=%04h required=none", sample_data);
        end else begin
          exp_w = exp_q.pop_front();
          chk("sample_data", int'(sample_data), int'(exp_w));
        end
      end

      if (overrun) ovr_seen++;

      if (conv_err) begin
        err_seen++;
        if (exp_err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_conv_err actual=1 required=0");
        end else begin
          chk("conv_err_latency", t_conv, exp_err_q.pop_front());
        end
      end

      if (ads_busy) busy_fall_t = -1;
      else if (prev_busy) busy_fall_t = 0;
      else if (busy_fall_t >= 0) busy_fall_t++;
      if (!ads_cs_n && prev_cs_n && busy_fall_t >= 0) begin
        chk("busy_to_cs_latency", busy_fall_t, 3);
        busy_fall_t = -1;
      end
      if (busy_fall_t > 20) busy_fall_t = -1;

      if (!ads_cs_n) begin
        cs_low_total++;
        read_len++;
        if (ads_sclk) begin
          if (!prev_sclk) rises++;
          hi_len++;
          if (lo_len != 0) begin
            if (lo_len != 2) bad++;
            lo_len = 0;
          end
        end else begin
          lo_len++;
          if (hi_len != 0) begin
            if (hi_len != 2) bad++;
            hi_len = 0;
          end
        end
      end else if (read_len != 0) begin
        if (hi_len != 2) bad++;
        chk("sclk_rises", rises, 16);
        chk("sclk_phase_errs", bad, 0);
        chk("read_len", read_len, 64);
        chk("valid_at_cs_rise", int'(sample_valid), 1);
        chk("sclk_low_at_done", int'(ads_sclk), 0);
        read_len = 0; rises = 0; hi_len = 0; lo_len = 0; bad = 0;
      end
    end
    prev_sclk = ads_sclk;
    prev_cs_n = ads_cs_n;
    prev_busy = ads_busy;
  end

  // mode 0: nominal BUSY (50 cycles), 1: stuck low, 2: stuck high
  task automatic do_conv(input logic [15:0] w, input int mode, input int ovr_at,
                         input bit expect_ok, input int win);
    bit risen;
    int rise_at;
    adc_word = w;
    if (expect_ok) exp_q.push_back(w);
    if (mode == 1) exp_err_q.push_back(200);
    if (mode == 2) exp_err_q.push_back(203);
    @(posedge sys_clk); #1 sample_en = 1'b1;
    risen = 1'b0;
    rise_at = 0;
    for (int t = 1; t < win; t++) begin
      @(posedge sys_clk); #1;
      sample_en = (t == ovr_at);
      if (!risen && ads_convst_n === 1'b1) begin
        risen = 1'b1;
        rise_at = t;
        if (mode != 1) ads_busy = 1'b1;
      end
      if (risen && mode == 0 && t == rise_at + 50) ads_busy = 1'b0;
    end
    sample_en = 1'b0;
    ads_busy = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_convst_n"}, int'(ads_convst_n), 1);
    chk({tag, "_cs_n"},     int'(ads_cs_n), 1);
    chk({tag, "_sclk"},     int'(ads_sclk), 0);
    chk({tag, "_data"},     int'(sample_data), 0);
    chk({tag, "_valid"},    int'(sample_valid), 0);
    chk({tag, "_overrun"},  int'(overrun), 0);
    chk({tag, "_conv_err"}, int'(conv_err), 0);
  endtask

  int v0, o0, e0, c0;

  initial begin
    #3 sys_rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Nominal
    v0 = vld_seen;
    do_conv(16'hA5C3, 0, 0, 1'b1, 200);
    chk("nominal_valid_count", vld_seen - v0, 1);
    chk("nominal_data", int'(sample_data), 16'hA5C3);

    // Back-to-back
    v0 = vld_seen; o0 = ovr_seen;
    do_conv(16'h0000, 0, 0, 1'b1, 200);
    do_conv(16'hFFFF, 0, 0, 1'b1, 200);
    do_conv(16'h8001, 0, 0, 1'b1, 200);
    chk("b2b_valid_count", vld_seen - v0, 3);
    chk("b2b_overrun_count", ovr_seen - o0, 0);

    // Overrun
    v0 = vld_seen; o0 = ovr_seen;
    do_conv(16'h1357, 0, 20, 1'b1, 200);
    chk("ovr_valid_count", vld_seen - v0, 1);
    chk("ovr_overrun_count", ovr_seen - o0, 1);

    // BUSY stuck low
    v0 = vld_seen; e0 = err_seen; c0 = cs_low_total;
    do_conv(16'hBEEF, 1, 0, 1'b0, 300);
    chk("stuck_lo_valid_count", vld_seen - v0, 0);
    chk("stuck_lo_err_count", err_seen - e0, 1);
    chk("stuck_lo_cs_low_cycles", cs_low_total - c0, 0);
    chk("stuck_lo_data_kept", int'(sample_data), 16'h1357);

    // BUSY stuck high, then recovery
    v0 = vld_seen; e0 = err_seen;
    do_conv(16'hCAFE, 2, 0, 1'b0, 300);
    chk("stuck_hi_valid_count", vld_seen - v0, 0);
    chk("stuck_hi_err_count", err_seen - e0, 1);
    do_conv(16'h2468, 0, 0, 1'b1, 200);
    chk("recover_data", int'(sample_data), 16'h2468);

    // Reset after the 7th sclk rising edge
    fork
      do_conv(16'hDEAD, 0, 0, 1'b0, 200);
      begin : rst_mid_read
        int   r;
        logic ps;
        r = 0;
        ps = 1'b0;
        for (int i = 0; i < 400 && r < 7; i++) begin
          @(posedge sys_clk); #1;
          if (ads_sclk && !ps) r++;
          ps = ads_sclk;
        end
        chk("mid_read_rises_seen", r, 7);
        #2 sys_rst_n = 1'b0;
        #1 chk_reset_vals("mid_read_reset");
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
      end
    join
    v0 = vld_seen;
    do_conv(16'h1234, 0, 0, 1'b1, 200);
    chk("post_reset_valid_count", vld_seen - v0, 1);

    for (int i = 0; i < 100 && (exp_q.size() != 0 || exp_err_q.size() != 0); i++)
      @(posedge sys_clk);
    chk("pending_valids", exp_q.size(), 0);
    chk("pending_conv_errs", exp_err_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
